fetch_queue: RTL and testbench

Parametrised successor to the single-instruction fetch stage. It fetches up to FETCH_WIDTH 32-bit instructions per cycle from the flat instruction-ROM bus into an in-order instruction queue, and hands them one per cycle to decode over a valid/ready handshake. It also supports PC redirect with queue flush and backpressure from decode. It sits between the ROM image held at the top level and the decode stage, replacing the free-running PC-plus-4 fetch.

---
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Multi-wide instruction fetch into an in-order queue, drained one entry per
//   cycle towards decode over a valid/ready handshake. Supports PC redirect
//   with queue flush and stalls fetch when the queue cannot take a full group.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   instr_rom       flat ROM image, word i at [i*32 +: 32]
//   rom_size        program size in bytes (multiple of 4, static after reset)
//   redirect_valid  flush queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address (bits [1:0] ignored)
//   out_valid       queue head valid
//   out_ready       decode accepts the head this cycle
//   out_instr       head instruction (0 when empty)
//   out_pc          head instruction byte address (0 when empty)
//   count           current queue occupancy
//   fetch_complete  program fully fetched and queue drained
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter  int ROM_WORDS   = 256,
    parameter  int FETCH_WIDTH = 2,
    parameter  int QUEUE_DEPTH = 8,
    localparam int CW          = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROM_WORDS*32-1:0] instr_rom,
    input  logic [31:0]            rom_size,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [31:0]            out_pc,
    output logic [CW-1:0]          count,
    output logic                   fetch_complete
);

    localparam int          PW        = $clog2(QUEUE_DEPTH);
    localparam int          AW        = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS * 4);

    // Word view of the flat ROM bus.
    logic [31:0] rom_words [ROM_WORDS];
    for (genvar g = 0; g < ROM_WORDS; g++) begin : g_rom
        assign rom_words[g] = instr_rom[g*32 +: 32];
    end

    logic [31:0]   pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_q [QUEUE_DEPTH];
    logic [31:0]   pc_q    [QUEUE_DEPTH];

    logic [31:0]   limit;
    logic [31:0]   remaining_words;
    logic [CW-1:0] free;
    logic          fetch_en;
    logic [CW-1:0] fetch_k;
    logic          pop;
    logic [31:0]   fetch_pc    [FETCH_WIDTH];
    logic [31:0]   fetch_instr [FETCH_WIDTH];

    assign limit           = (rom_size < ROM_BYTES) ? rom_size : ROM_BYTES;
    assign remaining_words = (limit - pc) >> 2;
    // Free space uses the pre-pop occupancy, so a full group always fits.
    assign free            = CW'(QUEUE_DEPTH) - count;
    assign fetch_en        = !reset && !redirect_valid && (pc < limit) &&
                             (free >= CW'(FETCH_WIDTH));
    assign pop             = out_valid && out_ready && !reset && !redirect_valid;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        fetch_k = '0;
        if (fetch_en) begin
            // The final group may be partial when fewer words remain than the fetch width.
            fetch_k = (remaining_words < 32'(FETCH_WIDTH)) ? CW'(remaining_words)
                                                           : CW'(FETCH_WIDTH);
        end
    end

    always_comb begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetch_pc[i]    = pc + 32'(4 * i);
            fetch_instr[i] = rom_words[fetch_pc[i][AW+1:2]];
        end
    end

    // NOTE: queue storage is deliberately not reset; count and the pointers define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (CW'(i) < fetch_k) begin
                instr_q[wr_ptr + PW'(i)] <= fetch_instr[i];
                pc_q[wr_ptr + PW'(i)]    <= fetch_pc[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc & ~32'd3;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            pc     <= pc + (32'(fetch_k) << 2);
            wr_ptr <= wr_ptr + PW'(fetch_k);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count  <= count + fetch_k - CW'(pop);
        end
    end

    assign out_valid      = (count != '0);
    assign out_instr      = out_valid ? instr_q[rd_ptr] : '0;
    assign out_pc         = out_valid ? pc_q[rd_ptr]    : '0;
    assign fetch_complete = (pc >= limit) && (count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed tests for fetch_queue (ROM_WORDS=256, FETCH_WIDTH=2,
//   QUEUE_DEPTH=8) plus a random-backpressure / random-redirect scoreboard.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int ROM_WORDS   = 256;
    localparam int FETCH_WIDTH = 2;
    localparam int QUEUE_DEPTH = 8;
    localparam int CW          = $clog2(QUEUE_DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [ROM_WORDS*32-1:0] instr_rom;
    logic [31:0]             rom_size = 32'd0;
    logic                    redirect_valid = 1'b0;
    logic [31:0]             redirect_pc = 32'd0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [31:0]             out_instr;
    logic [31:0]             out_pc;
    logic [CW-1:0]           count;
    logic                    fetch_complete;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .ROM_WORDS  (ROM_WORDS),
        .FETCH_WIDTH(FETCH_WIDTH),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_rom     (instr_rom),
        .rom_size      (rom_size),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .count         (count),
        .fetch_complete(fetch_complete)
    );

    function automatic logic [31:0] rom_word(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0001_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] size);
        rom_size       = size;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pops;
        int maxc;
        logic seen;
        logic over;
        logic [31:0] exp_pc;

        for (int i = 0; i < ROM_WORDS; i++) begin
            instr_rom[i*32 +: 32] = rom_word(i);
        end

        // ---- Test 1: rom_size=20, out_ready from reset release ----
        do_reset(32'd20);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(fetch_complete), 32'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_pc", out_pc, 32'(4 * i));
            check("t1_instr", out_instr, rom_word(i));
            if (i == 4) check("t1_done_early", 32'(fetch_complete), 32'd0);
        end
        tick();
        check("t1_done", 32'(fetch_complete), 32'd1);
        check("t1_empty", 32'(out_valid), 32'd0);

        // ---- Test 2: rom_size=12, k=2 then k=1 ----
        do_reset(32'd12);
        reset     = 1'b0;
        out_ready = 1'b1;
        pops = 0;
        maxc = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (int'(count) > maxc) maxc = int'(count);
            if (out_valid && out_ready) begin
                check("t2_pc", out_pc, 32'(4 * pops));
                pops++;
            end
        end
        check("t2_pops", 32'(pops), 32'd3);
        check("t2_maxcount", 32'(maxc), 32'd2);

        // ---- Test 3: saturation with out_ready=0, then drain ----
        do_reset(32'd64);
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (8) tick();
        check("t3_full", 32'(count), 32'd8);
        check("t3_int_pc", dut.pc, 32'd32);
        check("t3_not_done", 32'(fetch_complete), 32'd0);
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 100 && pops < 16; c++) begin
            if (out_valid) begin
                check("t3_pc", out_pc, 32'(4 * pops));
                check("t3_instr", out_instr, rom_word(pops));
                pops++;
            end
            tick();
        end
        check("t3_pops", 32'(pops), 32'd16);
        check("t3_done", 32'(fetch_complete), 32'd1);

        // ---- Test 4: redirect mid-stream with count=5 ----
        do_reset(32'd20);
        reset     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("t4_count5", 32'(count), 32'd5);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000A;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("t4_flush_count", 32'(count), 32'd0);
        check("t4_flush_valid", 32'(out_valid), 32'd0);
        tick();
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin
                check("t4_pc", out_pc, 32'h8 + 32'(4 * pops));
                check("t4_instr", out_instr, rom_word(2 + pops));
                pops++;
            end
            tick();
        end
        check("t4_pops", 32'(pops), 32'd3);

        // ---- Test 5a: reset wins over redirect ----
        rom_size       = 32'd64;
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        check("t5_rst_count", 32'(count), 32'd0);
        tick();
        check("t5_rst_valid", 32'(out_valid), 32'd1);
        check("t5_rst_pc", out_pc, 32'd0);

        // ---- Test 5b: empty program ----
        do_reset(32'd0);
        check("t5_zero_done", 32'(fetch_complete), 32'd1);
        reset     = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen |= out_valid;
        end
        check("t5_zero_never_valid", 32'(seen), 32'd0);
        check("t5_zero_done_hold", 32'(fetch_complete), 32'd1);

        // ---- Test 5c: redirect beyond limit, then back inside ----
        do_reset(32'd20);
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        check("t5_far_done", 32'(fetch_complete), 32'd1);
        tick();
        check("t5_far_idle", 32'(count), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0004;
        tick();
        redirect_valid = 1'b0;
        check("t5_back_not_done", 32'(fetch_complete), 32'd0);
        tick();
        check("t5_back_pc", out_pc, 32'd4);

        // ---- Test 6: random backpressure and redirects ----
        do_reset(32'd1024);
        reset  = 1'b0;
        exp_pc = 32'd0;
        over   = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            out_ready      = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = 32'($urandom_range(0, 1100));
            if (!redirect_valid && out_valid && out_ready) begin
                check("t6_pc", out_pc, exp_pc);
                check("t6_instr", out_instr, rom_word(int'(exp_pc >> 2)));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
            if (int'(count) > QUEUE_DEPTH) over = 1'b1;
            tick();
        end
        redirect_valid = 1'b0;
        check("t6_count_bound", 32'(over), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
